// File: rtl/bin2seg_pkg.sv
// bin2seg_pkg: shared constants and FSM state type for the sequential seven-segment converter.
package bin2seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Active-low patterns, bit 0 = a ... bit 6 = g; non-BCD codes stay dark.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_e;

endpackage

// File: rtl/bin2seg_seq_decode.sv
// seg7_decode: combinational BCD nibble to active-low seven-segment pattern.
module seg7_decode
    import bin2seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[digit_i];

endmodule

// File: rtl/bin2seg_seq.sv
// bin2seg_seq: handshaked iterative double-dabble binary to BCD/seven-segment converter.
// Define BIN2SEG_SIGNED_EN to treat bin as two's complement and show a minus sign.
module bin2seg_seq
    import bin2seg_pkg::*;
#(
    parameter int BIN_W  = 11,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  blank_lz,
    output logic                  out_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  ovf
);

    localparam int CW = $clog2(BIN_W + 1);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [BIN_W-1:0]      sh_q;
    logic [BIN_W-1:0]      mag;
    logic [4*DIGITS-1:0]   acc_q;
    logic [4*DIGITS-1:0]   acc_d;
    logic [4*DIGITS-1:0]   adj;
    logic                  ovf_acc_q;
    logic                  blz_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [7*DIGITS-1:0]   seg_q;
    logic [7*DIGITS-1:0]   seg_d;
    logic [7*DIGITS-1:0]   raw;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  out_valid_q;
    logic [DIGITS-1:0]     lz;
    logic [DIGITS-1:0]     minus;
    logic                  zero_run;

    // Add-3 correction per digit; lz marks zero digits above the most significant non-zero one.
    always_comb begin
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            adj[4*k +: 4] = acc_q[4*k +: 4] + (acc_q[4*k +: 4] >= 4'd5 ? 4'd3 : 4'd0);
            zero_run = zero_run && acc_q[4*k +: 4] == 4'd0;
            lz[k] = zero_run && k != 0;
        end
    end

    assign acc_d = {adj[4*DIGITS-2:0], sh_q[BIN_W-1]};

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        seg7_decode u_dec (.digit_i(acc_q[4*k +: 4]), .seg_o(raw[7*k +: 7]));
    end

`ifdef BIN2SEG_SIGNED_EN
    localparam logic [DIGITS-1:0] TOP = DIGITS'(1) << (DIGITS - 1);
    logic              neg_q;
    logic [DIGITS-1:0] lz_lo;
    assign lz_lo = DIGITS'({lz, 1'b1});
    assign mag   = bin[BIN_W-1] ? -bin : bin;
    // Minus sits just left of the top digit when a blank slot exists, else on the top display.
    assign minus = !neg_q ? '0 : (blz_q && lz[DIGITS-1]) ? lz & ~lz_lo : TOP;
    assign ovf_d = ovf_acc_q | (neg_q & ~lz[DIGITS-1]);
`else
    assign mag   = bin;
    assign minus = '0;
    assign ovf_d = ovf_acc_q;
`endif

    always_comb begin
        for (int k = 0; k < DIGITS; k++)
            seg_d[7*k +: 7] = minus[k] ? SEG_MINUS : (blz_q && lz[k]) ? SEG_BLANK : raw[7*k +: 7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            blz_q       <= 1'b0;
            bcd_q       <= '0;
            seg_q       <= '1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BIN2SEG_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    sh_q      <= mag;
                    blz_q     <= blank_lz;
                    acc_q     <= '0;
                    ovf_acc_q <= 1'b0;
                    cnt_q     <= CW'(BIN_W);
                    state_q   <= SHIFT;
`ifdef BIN2SEG_SIGNED_EN
                    neg_q     <= bin[BIN_W-1];
`endif
                end
                SHIFT: begin
                    acc_q     <= acc_d;
                    sh_q      <= sh_q << 1;
                    ovf_acc_q <= ovf_acc_q | adj[4*DIGITS-1];
                    cnt_q     <= cnt_q - CW'(1);
                    state_q   <= cnt_q == CW'(1) ? ENCODE : SHIFT;
                end
                default: begin
                    bcd_q       <= acc_q;
                    seg_q       <= seg_d;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign seg       = seg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2seg_seq.sv
// tb_bin2seg_seq: randomized and directed check of two bin2seg_seq instances (11-bit and 14-bit, 4 digits).
module tb_bin2seg_seq;

    localparam logic [44:0] RST = {1'b0, 16'h0, 28'hFFFFFFF};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [13:0] bin = '0;
    logic [1:0]  rdy, bsy, ovv, ovf;
    logic [15:0] bcd0, bcd1;
    logic [27:0] seg0, seg1;
    int          nvec = 0, nerr = 0, cyc = 0;

    int          cnt [2] = '{0, 0};
    logic        ev [2] = '{1'b0, 1'b0};
    logic [44:0] held [2] = '{RST, RST};
    logic [44:0] pend [2];
    logic [6:0]  segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bin2seg_seq #(.BIN_W(11), .DIGITS(4)) u11 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .bin(bin[10:0]),
        .blank_lz(blank_lz), .out_valid(ovv[0]), .busy(bsy[0]), .bcd(bcd0), .seg(seg0), .ovf(ovf[0]));

    bin2seg_seq #(.BIN_W(14), .DIGITS(4)) u14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .bin(bin),
        .blank_lz(blank_lz), .out_valid(ovv[1]), .busy(bsy[1]), .bcd(bcd1), .seg(seg1), .ovf(ovf[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic int wid(input int d);
        return d == 0 ? 11 : 14;
    endfunction

    // Expected {ovf, bcd, seg} computed from the decimal value of the word.
    function automatic logic [44:0] model(input int w, input logic [13:0] b, input logic blz);
        int v, m, msd, pw;
        int dg [4];
        logic [27:0] s;
        logic [15:0] bc;
        logic o;
        v = int'(b) & ((1 << w) - 1);
        m = v;
`ifdef BIN2SEG_SIGNED_EN
        if (b[w-1]) m = (1 << w) - v;
`endif
        o = m >= 10000;
        msd = 0;
        pw = 1;
        for (int k = 0; k < 4; k++) begin
            dg[k] = (m / pw) % 10;
            if (dg[k] != 0) msd = k;
            pw = pw * 10;
        end
        for (int k = 0; k < 4; k++) begin
            s[7*k +: 7] = (blz && k > msd) ? 7'h7F : segtab[dg[k]];
            bc[4*k +: 4] = 4'(dg[k]);
        end
`ifdef BIN2SEG_SIGNED_EN
        if (b[w-1]) begin
            if (blz && msd < 3) s[7*(msd+1) +: 7] = 7'b0111111;
            else begin
                s[27:21] = 7'b0111111;
                if (msd == 3) o = 1'b1;
            end
        end
`endif
        return {o, bc, s};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                cnt[d] = 0;
                ev[d] = 1'b0;
                held[d] = RST;
            end else begin
                ev[d] = 1'b0;
                if (cnt[d] == 0) begin
                    if (in_valid) begin
                        cnt[d] = wid(d) + 1;
                        pend[d] = model(wid(d), bin, blank_lz);
                    end
                end else begin
                    cnt[d]--;
                    if (cnt[d] == 0) begin
                        held[d] = pend[d];
                        ev[d] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [47:0] expobs(input int d);
        return {cnt[d] == 0, cnt[d] != 0, ev[d], held[d]};
    endfunction

    initial forever begin
        @(negedge clk);
        chk("cyc_u11", {rdy[0], bsy[0], ovv[0], ovf[0], bcd0, seg0}, expobs(0));
        chk("cyc_u14", {rdy[1], bsy[1], ovv[1], ovf[1], bcd1, seg1}, expobs(1));
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy == 2'b11) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input logic [13:0] b, input logic blz, output int t0);
        @(posedge clk);
        #1 bin = b; blank_lz = blz; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        int t0, last;
        logic [13:0] r;
        logic [13:0] picks [7] = '{14'd0, 14'd9999, 14'd10000, 14'd16383, 14'd8192, 14'd1023, 14'd999};
        repeat (3) @(negedge clk);
        chk("rst_u11", {rdy[0], bsy[0], ovv[0], ovf[0], bcd0, seg0}, {3'b100, RST});
        chk("rst_u14", {rdy[1], bsy[1], ovv[1], ovf[1], bcd1, seg1}, {3'b100, RST});
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle();

`ifdef BIN2SEG_SIGNED_EN
        send(14'h07FB, 1'b1, t0);
        wait_idle();
        chk("neg5_seg", seg0, {7'h7F, 7'h7F, 7'b0111111, 7'b0010010});
        chk("neg5_bcd", bcd0, 16'h0005);
        chk("neg5_ovf", ovf[0], 1'b0);
`else
        send(14'd2047, 1'b0, t0);
        for (int i = 0; i < 40 && !ovv[0]; i++) @(negedge clk);
        chk("lat_u11", cyc - t0, 12);
        wait_idle();
        chk("b2047_bcd", bcd0, 16'h2047);
        chk("b2047_seg", seg0, {7'b0100100, 7'b1000000, 7'b0011001, 7'b1111000});
        chk("b2047_ovf", ovf[0], 1'b0);
        send(14'd0, 1'b1, t0);
        wait_idle();
        chk("zero_seg", seg0, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
        chk("zero_ovf", {ovf[0], bcd0}, 17'h0);
        send(14'd12345, 1'b0, t0);
        wait_idle();
        chk("ovf_u14", {ovf[1], bcd1}, {1'b1, 16'h2345});
        chk("mod_u11", bcd0, 16'h0057);
`endif

        for (int n = 0; n < 40; n++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 6)] : 14'($urandom);
            send(r, 1'($urandom), t0);
        end

        wait_idle();
        @(posedge clk);
        #1 in_valid = 1'b1;
        last = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ovv[0]) begin
                if (last >= 0) chk("tput_u11", cyc - last, 13);
                last = cyc;
            end
            bin = 14'($urandom);
            blank_lz = 1'($urandom);
        end
        in_valid = 1'b0;

        wait_idle();
        send(14'($urandom), 1'b0, t0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_u11", {rdy[0], bsy[0], ovv[0], ovf[0], bcd0, seg0}, {3'b100, RST});
        chk("abort_u14", {rdy[1], bsy[1], ovv[1], ovf[1], bcd1, seg1}, {3'b100, RST});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bin2seg_seq.md
# bin2seg_seq

Sequential, parametrised binary-to-seven-segment converter that succeeds the combinational three-digit decoder. It accepts a binary word through a valid/ready handshake and runs an iterative double-dabble, one bit per clock. It then registers BCD digits and active-low segment patterns for `DIGITS` displays, with optional leading-zero blanking and an overflow flag. It sits between score/counter logic and the board's HEX displays.

## Interface
- `BIN_W` — default 11 — input word width, ≥ 4.
- `DIGITS` — default 4 — number of decimal digits/displays, 1..8.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — `bin`/`blank_lz` valid.
- `in_ready`  out  1  — block can accept a word.
- `bin`  in  `BIN_W`  — value to convert.
- `blank_lz`  in  1  — blank leading zeros; captured with `bin`.
- `out_valid`  out  1  — one-cycle pulse when new result is registered.
- `busy`  out  1  — conversion in progress.
- `bcd`  out  `4*DIGITS`  — BCD result; digit k at `[4k+3:4k]`, digit 0 = units.
- `seg`  out  `7*DIGITS`  — active-low segments; display k at `[7k+6:7k]`, bit 0 = a … bit 6 = g.
- `ovf`  out  1  — value did not fit in `DIGITS` digits.

## Operation
- States:
  - IDLE: `in_ready=1`; `in_valid` high → capture `bin`, `blank_lz`, clear BCD shift register and `ovf` accumulator, load bit counter with `BIN_W`, go SHIFT.
  - SHIFT: per cycle, add 3 to every BCD digit ≥ 5, then shift left one bit, taking the next input bit MSB-first. Any 1 shifted out of digit `DIGITS-1` sets the `ovf` accumulator. Counter reaching 0 → go ENCODE.
  - ENCODE: register `bcd`, `seg`, `ovf`; pulse `out_valid`; go IDLE.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-BCD nibble → 1111111.
- Blanking: with `blank_lz`=1, every digit above the most significant non-zero digit shows 1111111. Digit 0 is never blanked, so value 0 shows "0". `bcd` itself is never blanked.
- Overflow: `seg`/`bcd` show the low `DIGITS` digits (value mod 10^DIGITS), with `ovf`=1.
- `in_valid` outside IDLE is ignored; no queuing.

## Timing
- Reset values: `in_ready`=1, `busy`=0, `out_valid`=0, `ovf`=0, `bcd`=0, `seg` all 1111111, state IDLE.
- Accept at edge N → `out_valid` high during the cycle after edge N+`BIN_W`+1 (latency `BIN_W`+1 edges).
- `in_ready` returns high in the same cycle `out_valid` is high. A word presented then is accepted at the next edge. Throughput: one word per `BIN_W`+2 cycles.
- `busy` = state is not IDLE.
- `seg`/`bcd`/`ovf` hold their values between ENCODE cycles.
- `rst_n` low mid-conversion aborts immediately to reset values. No `out_valid` is produced for the aborted word.

## Configuration
- `BIN2SEG_SIGNED_EN` defined:
  - `bin` is two's complement. Negative values convert their `BIN_W`-bit magnitude, so the most-negative value is handled.
  - Minus sign = 0111111.
  - With `blank_lz`=1, the minus occupies the blank digit immediately left of the most significant digit.
  - With `blank_lz`=0, the minus replaces digit `DIGITS-1`.
  - If no digit is free for the minus, `ovf`=1 and the minus still occupies digit `DIGITS-1`.
  - `bcd` always holds the magnitude.
- Not defined: `bin` is unsigned; there is no sign logic.

## Structure
- Package `bin2seg_pkg`:
  - `SEG_BLANK` and `SEG_MINUS` constants.
  - Digit→segment lookup constants.
  - State enum type (IDLE/SHIFT/ENCODE).
- Sub-module `seg7_decode`: combinational 4-bit → 7-bit decoder, instantiated `DIGITS` times inside ENCODE datapath.

## Test plan
- Reset: hold `rst_n`=0 → `seg`=all 1111111, `bcd`=0, `in_ready`=1, `out_valid`=0, `ovf`=0.
- `BIN_W`=11, `DIGITS`=4, `bin`=2047, `blank_lz`=0 → `bcd`=0x2047, `seg` = 2,0,4,7 patterns, `out_valid` exactly 12 edges after accept.
- `bin`=0, `blank_lz`=1 → digit 0 = 1000000, digits 1–3 = 1111111, `ovf`=0.
- `BIN_W`=14, `DIGITS`=4, `bin`=12345 → `ovf`=1, `bcd`=0x2345.
- `in_valid` held high across conversions → `in_ready`=0 while `busy`, second word accepted on the `out_valid` cycle's next edge; deassert `rst_n` mid-SHIFT → immediate reset values, no `out_valid`.
- With `BIN2SEG_SIGNED_EN`, `BIN_W`=11, `bin`=-5, `blank_lz`=1 → digit 1 = 0111111, digit 0 = 0010010, digits 2–3 blank, `bcd`=0x0005.
